// File: rtl/sub_serial_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface sub_serial_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sub;
   logic             borrow_out;
   logic             busy;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Sub, borrow_out, busy
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Sub, borrow_out, busy
   );
endinterface

// File: rtl/sub_serial_ctrl.sv
// Bit-serial A - B sequencer: one full-subtractor cell plus a borrow register,
// LSB first, one bit per clock, with valid/ready on both operand and result sides.
module sub_serial_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   sub_serial_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q,     state_d;
   logic [WIDTH-1:0]   op_a_q,      op_a_d;
   logic [WIDTH-1:0]   op_b_q,      op_b_d;
   logic [WIDTH-1:0]   res_q,       res_d;
   logic [WIDTH-1:0]   sub_q,       sub_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               borrow_q,    borrow_d;
   logic               bout_q,      bout_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q,      busy_d;

   logic               bit_a, bit_b, bit_d, bit_bout;

   // Full-subtractor cell on the current LSBs.
   always_comb begin
      bit_a    = op_a_q[0];
      bit_b    = op_b_q[0];
      bit_d    = bit_a ^ bit_b ^ borrow_q;
      bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
   end

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      res_d    = res_q;
      sub_d    = sub_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               op_a_d   = bus.A;
               op_b_d   = bus.B;
               cnt_d    = '0;
               borrow_d = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // New bit enters at the MSB so that after WIDTH shifts bit i is difference bit i.
            res_d    = WIDTH'({bit_d, res_q} >> 1);
            op_a_d   = op_a_q >> 1;
            op_b_d   = op_b_q >> 1;
            borrow_d = bit_bout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               sub_d   = res_d;
               bout_d  = bit_bout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_q       <= '0;
         sub_q       <= '0;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         res_q       <= res_d;
         sub_q       <= sub_d;
         cnt_q       <= cnt_d;
         borrow_q    <= borrow_d;
         bout_q      <= bout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.Sub        = sub_q;
   assign bus.borrow_out = bout_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Bench for sub_serial_ctrl: directed cases on an 8-bit instance, then random
// traffic on 8-bit and 1-bit instances against an arithmetic reference model.
module tb_sub_serial_ctrl;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sub_serial_ctrl_if #(.WIDTH(8)) bus8 ();
   sub_serial_ctrl_if #(.WIDTH(1)) bus1 ();

   sub_serial_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   sub_serial_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready8"},  32'(bus8.in_ready),   32'd1);
      check({tag, "_out_valid8"}, 32'(bus8.out_valid),  32'd0);
      check({tag, "_busy8"},      32'(bus8.busy),       32'd0);
      check({tag, "_sub8"},       32'(bus8.Sub),        32'd0);
      check({tag, "_borrow8"},    32'(bus8.borrow_out), 32'd0);
      check({tag, "_in_ready1"},  32'(bus1.in_ready),   32'd1);
      check({tag, "_out_valid1"}, 32'(bus1.out_valid),  32'd0);
      check({tag, "_sub1"},       32'(bus1.Sub),        32'd0);
   endtask

   // Wait for in_ready, issue one pair, check latency, result and return to IDLE.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold);
      int         n;
      logic [8:0] exp;
      exp = {1'b0, a} - {1'b0, b};
      n = 0;
      while (!bus8.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("op_ready", 32'(bus8.in_ready), 32'd1);
      bus8.A         = a;
      bus8.B         = b;
      bus8.in_valid  = 1'b1;
      bus8.out_ready = (hold == 0);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.A        = ~a;
      bus8.B        = 8'($urandom);
      check("op_busy_after_accept",  32'(bus8.busy),     32'd1);
      check("op_ready_after_accept", 32'(bus8.in_ready), 32'd0);
      n = 0;
      while (!bus8.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("op_latency", 32'(n), 32'd8);
      check("op_result",  32'({bus8.borrow_out, bus8.Sub}), 32'(exp));
      check("op_ready_in_done", 32'(bus8.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_valid",  32'(bus8.out_valid), 32'd1);
         check("bp_result", 32'({bus8.borrow_out, bus8.Sub}), 32'(exp));
         check("bp_ready",  32'(bus8.in_ready),  32'd0);
      end
      bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.out_ready = 1'b0;
      check("op_valid_cleared", 32'(bus8.out_valid), 32'd0);
      check("op_ready_back",    32'(bus8.in_ready),  32'd1);
      check("op_busy_cleared",  32'(bus8.busy),      32'd0);
      check("op_result_kept",   32'({bus8.borrow_out, bus8.Sub}), 32'(exp));
   endtask

   initial begin
      logic [8:0] q8[$];
      logic [1:0] q1[$];
      logic [8:0] e8;
      logic [1:0] e1;
      int         n;
      int         cyc;
      int         acc8, acc1, done8, done1, last8, last1, stale;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.A = '0; bus8.B = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.A = '0; bus1.B = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      op8(8'd10,  8'd3,  0);
      op8(8'd3,   8'd10, 0);
      op8(8'd0,   8'd1,  0);
      op8(8'h80,  8'h80, 0);
      op8(8'hC3,  8'h5A, 5);

      // Reset in the middle of a RUN phase.
      bus8.A = 8'd200; bus8.B = 8'd50; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midop_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus8.out_valid) stale++;
      end
      check("midop_no_stale_valid", 32'(stale), 32'd0);
      check("midop_sub_cleared",    32'(bus8.Sub), 32'd0);
      bus8.out_ready = 1'b0;
      op8(8'd5, 8'd9, 0);

      // Random traffic on both widths with random in_valid/out_ready gaps.
      acc8 = 0; acc1 = 0; done8 = 0; done1 = 0;
      last8 = -100; last1 = -100; cyc = 0;
      while ((done8 < 1000 || done1 < 1000) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         bus8.in_valid  = (acc8 < 1000) && ($urandom_range(3) != 0);
         bus8.A         = 8'($urandom);
         bus8.B         = 8'($urandom);
         bus8.out_ready = ($urandom_range(3) != 0);
         bus1.in_valid  = (acc1 < 1000) && ($urandom_range(3) != 0);
         bus1.A         = 1'($urandom);
         bus1.B         = 1'($urandom);
         bus1.out_ready = ($urandom_range(2) != 0);

         if (bus8.in_valid && bus8.in_ready) begin
            q8.push_back({1'b0, bus8.A} - {1'b0, bus8.B});
            check("rnd8_interval", 32'(cyc - last8 >= 10), 32'd1);
            last8 = cyc;
            acc8++;
         end
         if (bus8.out_valid && bus8.out_ready) begin
            e8 = (q8.size() > 0) ? q8.pop_front() : 9'bx;
            check("rnd8_result", 32'({bus8.borrow_out, bus8.Sub}), 32'(e8));
            done8++;
         end
         if (bus1.in_valid && bus1.in_ready) begin
            q1.push_back({1'b0, bus1.A} - {1'b0, bus1.B});
            check("rnd1_interval", 32'(cyc - last1 >= 3), 32'd1);
            last1 = cyc;
            acc1++;
         end
         if (bus1.out_valid && bus1.out_ready) begin
            e1 = (q1.size() > 0) ? q1.pop_front() : 2'bx;
            check("rnd1_result", 32'({bus1.borrow_out, bus1.Sub}), 32'(e1));
            done1++;
         end
      end
      check("rnd8_completed", 32'(done8), 32'd1000);
      check("rnd1_completed", 32'(done1), 32'd1000);
      n = q8.size() + q1.size();
      check("rnd_queues_empty", 32'(n), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sub_serial_ctrl.md
Name: sub_serial_ctrl

Overview:
- Bit-serial sequencer for n-bit integer subtraction in the PIM synthesis benchmark set.
- Accepts one A/B operand pair through a valid/ready handshake and computes A - B LSB-first, one bit per cycle, using a single 1-bit full-subtractor cell and a borrow register.
- Returns the WIDTH-bit difference and the final borrow through a second valid/ready handshake.
- Serves as the time-multiplexed counterpart to the parallel n-bit subtractor: it trades latency for area, mirroring row-serial PIM execution.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 1 or more.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  WIDTH  minuend, unsigned or two's complement.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  Sub and borrow_out are valid.
- out_ready  input  1  consumer accepts the result.
- Sub  output  WIDTH  A - B mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when unsigned A < B.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous assert while rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - Sub=0, borrow_out=0.
  - Internal operand registers, bit counter and borrow register all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A and B into shift registers, set counter=0 and borrow=0, go to RUN.
- RUN (in_ready=0, busy=1), each cycle:
  - a = opA[0], b = opB[0], bin = borrow.
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
  - Shift d into the result register from the MSB side, so after WIDTH shifts bit i holds the bit-i difference.
  - Shift opA and opB right by one; borrow <= bout; counter <= counter + 1.
  - When counter == WIDTH-1 in a cycle, go to DONE on that edge.
  - Result and borrow_out are written together with the final bit.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - Sub and borrow_out hold stable until out_valid && out_ready.
  - On handshake: go to IDLE, out_valid <= 0.
  - Sub and borrow_out keep their last value in IDLE; they are not cleared.
- Latency:
  - Acceptance edge at cycle 0; out_valid is high in the cycle after edge WIDTH, i.e. WIDTH cycles in RUN.
  - Minimum issue interval is WIDTH+2 cycles with out_ready held high.
  - No overlap: in_ready stays low in DONE, even in the handshake cycle.
- Input changes during RUN or DONE are ignored.
- out_ready held high in IDLE or RUN has no effect.
- WIDTH=1: exactly one RUN cycle.
- Counter never wraps; it is compared against WIDTH-1 before incrementing past the limit.
- Reset mid-operation: the in-flight computation is discarded and no out_valid is produced. After release, the first accepted pair behaves as if after power-up.
- Arithmetic equivalence: {borrow_out, Sub} == ({1'b0,A} - {1'b0,B}) mod 2^(WIDTH+1) for all inputs.

Test Plan:
- WIDTH=8, A=10, B=3, out_ready=1 -> out_valid rises 8 cycles after acceptance; Sub=8'h07, borrow_out=0; in_ready is back to 1 two cycles later.
- A=3, B=10 -> Sub=8'hF9, borrow_out=1.
- A=0, B=1 -> Sub=8'hFF, borrow_out=1.
- A=8'h80, B=8'h80 -> Sub=0, borrow_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> Sub, borrow_out and out_valid stay stable and in_ready stays 0; on out_ready=1 the handshake completes and IDLE follows.
- Reset mid-op:
  - Accept A=200, B=50, then drop rst_n in RUN cycle 4 -> all outputs return to reset values asynchronously.
  - After release, A=5, B=9 -> Sub=8'hFC, borrow_out=1.
  - No stale result appears at any point.
- Randomized back-to-back: 1000 pairs with random in_valid/out_ready gaps, WIDTH=8 and WIDTH=1 -> every result matches the reference model, and issue interval is at least WIDTH+2 cycles.
